// File: rtl/ppu_update_scheduler_if.sv
// CPU request channel and PPU square-table write port of the update scheduler.
// master = CPU/PPU environment side, slave = scheduler side.
interface ppu_update_scheduler_if;
    logic        req_valid;
    logic        req_ready;
    logic [16:0] req_cmd;

    logic        receive;
    logic        board;
    logic [6:0]  square_update;
    logic [1:0]  square_state;
    logic [1:0]  ship_type;
    logic [2:0]  ship_section;
    logic        vert;
    logic        square_sel;

    modport master (
        output req_valid, req_cmd,
        input  req_ready,
        input  receive, board, square_update, square_state, ship_type, ship_section,
               vert, square_sel
    );

    modport slave (
        input  req_valid, req_cmd,
        output req_ready,
        output receive, board, square_update, square_state, ship_type, ship_section,
               vert, square_sel
    );
endinterface

// File: rtl/ppu_update_scheduler.sv
// Serialises CPU square updates and 100-square board clears into the PPU table,
// optionally holding writes until synchronised vblank.
module ppu_update_scheduler #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned VBLANK_GATE = 1
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    ppu_update_scheduler_if.slave bus,
    input  logic                  clr_req_i,
    input  logic                  clr_board_i,
    output logic                  clr_busy_o,
    input  logic                  vblank_async_i,
    output logic                  err_o
);
    localparam int unsigned AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PtrOne     = {{AW{1'b0}}, 1'b1};
    localparam logic [6:0]  LastSquare = 7'd99;
    localparam logic [6:0]  NumSquares = 7'd100;

    typedef enum logic [1:0] {StIdle, StDrain, StClear} state_e;

    state_e      state_q, state_d;
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [16:0] mem_q [FIFO_DEPTH];
    logic [6:0]  idx_q, idx_d;
    logic        busy_q, busy_d;
    logic        clr_brd_q, clr_brd_d;
    logic        vb_meta_q, vb_s_q;
    logic        err_q;
    logic        receive_q, receive_d;
    logic [16:0] out_q, out_d;
    logic [16:0] head;
    logic        gate, fifo_empty, fifo_full, accept, push, pop;

    assign gate       = (VBLANK_GATE != 0) ? vb_s_q : 1'b1;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    assign bus.req_ready = !fifo_full && (state_q == StIdle) && !busy_q;
    assign accept        = bus.req_valid && bus.req_ready;
    // Out-of-range squares are dropped here and only reported through err.
    assign push          = accept && (bus.req_cmd[15:9] < NumSquares);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        clr_brd_d = clr_brd_q;
        receive_d = 1'b0;
        out_d     = out_q;
        pop       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && gate) begin
                    pop       = 1'b1;
                    receive_d = 1'b1;
                    out_d     = head;
                end
                if (clr_req_i) begin
                    busy_d    = 1'b1;
                    clr_brd_d = clr_board_i;
                    state_d   = StDrain;
                end
            end
            StDrain: begin
                if (fifo_empty) begin
                    state_d = StClear;
                    idx_d   = 7'd0;
                end else if (gate) begin
                    pop       = 1'b1;
                    receive_d = 1'b1;
                    out_d     = head;
                end
            end
            StClear: begin
                if (gate) begin
                    receive_d = 1'b1;
                    out_d     = {clr_brd_q, idx_q, 9'd0};
                    if (idx_q == LastSquare) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + 7'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            idx_q     <= 7'd0;
            busy_q    <= 1'b0;
            clr_brd_q <= 1'b0;
            vb_meta_q <= 1'b0;
            vb_s_q    <= 1'b0;
            err_q     <= 1'b0;
            receive_q <= 1'b0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            clr_brd_q <= clr_brd_d;
            vb_meta_q <= vblank_async_i;
            vb_s_q    <= vb_meta_q;
            err_q     <= accept && !push;
            receive_q <= receive_d;
            out_q     <= out_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.req_cmd;
    end

    assign bus.receive = receive_q;
    assign {bus.board, bus.square_update, bus.square_state, bus.ship_type,
            bus.ship_section, bus.vert, bus.square_sel} = out_q;
    assign clr_busy_o  = busy_q;
    assign err_o       = err_q;
endmodule
